inst_trace_tx: RTL and testbench

Synthesizable retired-instruction trace transmitter per integer pipeline. Captures per-thread retire records (tid, pc, inst, replay/annul, DMA/microcode state, upc) at the exception/commit stage, buffers them in a record FIFO, and serializes each record as 32-bit words over a valid/ready stream. The stream feeds the host debug link, where software disassembles it. This is the hardware producer for the same trace content the simulation disassembler consumes.

---
 rtl/inst_trace_tx_if.sv | 19 +
 rtl/inst_trace_tx.sv | 167 ++++++++++++++++
 tb/tb_inst_trace_tx.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_trace_tx_if.sv
// ---------------------------------------------------------------------------
// inst_trace_tx_if
// Word stream from the retired-instruction trace transmitter to the host
// debug link.
//   out_valid : word valid (producer)
//   out_data  : 32-bit trace word (producer)
//   out_last  : final word of a record (producer)
//   out_ready : consumer accepts the word (consumer)
// master = transmitter side, slave = debug-link side.
// ---------------------------------------------------------------------------
interface inst_trace_tx_if;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_ready;

    modport master (output out_valid, output out_data, output out_last, input out_ready);
    modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/inst_trace_tx.sv
// ---------------------------------------------------------------------------
// inst_trace_tx
// Retired-instruction trace transmitter for one integer pipeline. Retire
// records are captured at the commit stage, buffered in a record FIFO and
// serialized as 32-bit words (header, pc, inst[, timestamp]) on a
// valid/ready stream.
//
// Ports:
//   gclk, rstn      : clock (rising edge), asynchronous active-low reset
//   trace_en        : capture enable
//   tr_valid        : retire record present
//   tr_tid/pc/inst  : thread id, pc, instruction word
//   tr_replay/annul/dma/uc, tr_upc : record flags and microcode pc
//   drop_cnt        : saturating count of dropped records
//   tx              : output word stream (inst_trace_tx_if.master)
//
// Optional feature macro: INST_TRACE_TSTAMP_EN -- adds a free-running 32-bit
// cycle counter latched at capture and sent as a fourth word.
// ---------------------------------------------------------------------------
module inst_trace_tx #(
    parameter int PID   = 0,
    parameter int DEPTH = 16,
    parameter int TIDW  = 5,
    parameter int UPCW  = 8
) (
    input  logic             gclk,
    input  logic             rstn,
    input  logic             trace_en,
    input  logic             tr_valid,
    input  logic [TIDW-1:0]  tr_tid,
    input  logic [31:0]      tr_pc,
    input  logic [31:0]      tr_inst,
    input  logic             tr_replay,
    input  logic             tr_annul,
    input  logic             tr_dma,
    input  logic             tr_uc,
    input  logic [UPCW-1:0]  tr_upc,
    output logic [7:0]       drop_cnt,
    inst_trace_tx_if.master  tx
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    typedef enum logic [2:0] {IDLE, HDR, PC, INST, TS} state_t;

`ifdef INST_TRACE_TSTAMP_EN
    localparam int     EW      = 128;
    localparam logic   TS_BIT  = 1'b1;
    localparam state_t LAST_ST = TS;
`else
    localparam int     EW      = 96;
    localparam logic   TS_BIT  = 1'b0;
    localparam state_t LAST_ST = INST;
`endif

    state_t            state, state_nxt;
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count, count_nxt;
    logic [7:0]        seq;
    logic              ovf;
    logic [EW-1:0]     mem [DEPTH];
    logic [EW-1:0]     head, wr_entry;
    logic [31:0]       hdr;
    logic              capture, accept, hs, pop;
    logic              valid_c, last_c;
    logic [31:0]       data_c;

    assign capture = trace_en & tr_valid;
    assign hs      = (state != IDLE) & tx.out_ready;
    assign pop     = hs & (state == LAST_ST);
    // A full FIFO still takes the record when the head leaves in the same cycle.
    assign accept  = capture & ((count != DEPTH_C) | pop);
    assign count_nxt = count + (AW+1)'(accept) - (AW+1)'(pop);

    assign hdr = {4'(PID), tr_replay, tr_annul, tr_dma, tr_uc, 8'(tr_upc),
                  seq, TS_BIT, ovf, 1'b0, 5'(tr_tid)};

`ifdef INST_TRACE_TSTAMP_EN
    logic [31:0] ts_cnt;

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) ts_cnt <= '0;
        else       ts_cnt <= ts_cnt + 32'd1;
    end

    assign wr_entry = {ts_cnt, tr_inst, tr_pc, hdr};
`else
    assign wr_entry = {tr_inst, tr_pc, hdr};
`endif

    // Record storage carries data only; occupancy lives in the pointers.
    always_ff @(posedge gclk) begin
        if (accept) mem[wr_ptr] <= wr_entry;
    end

    assign head = mem[rd_ptr];

    always_ff @(posedge gclk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            seq      <= '0;
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (capture) seq <= seq + 8'd1;
            // ovf is sampled into the header of the accepted record, then cleared.
            if (accept)       ovf <= 1'b0;
            else if (capture) ovf <= 1'b1;
            if (capture && !accept && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    always_comb begin
        state_nxt = state;
        valid_c   = 1'b0;
        last_c    = 1'b0;
        data_c    = '0;
        case (state)
            IDLE: begin
                if (count != '0) state_nxt = HDR;
            end
            HDR: begin
                valid_c = 1'b1;
                data_c  = head[31:0];
                if (hs) state_nxt = PC;
            end
            PC: begin
                valid_c = 1'b1;
                data_c  = head[63:32];
                if (hs) state_nxt = INST;
            end
            INST: begin
                valid_c = 1'b1;
                data_c  = head[95:64];
`ifdef INST_TRACE_TSTAMP_EN
                if (hs) state_nxt = TS;
`else
                last_c = 1'b1;
                // Go straight to the next header when more records are waiting.
                if (hs) state_nxt = (count_nxt != '0) ? HDR : IDLE;
`endif
            end
`ifdef INST_TRACE_TSTAMP_EN
            TS: begin
                valid_c = 1'b1;
                last_c  = 1'b1;
                data_c  = head[127:96];
                if (hs) state_nxt = (count_nxt != '0) ? HDR : IDLE;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    assign tx.out_valid = valid_c;
    assign tx.out_data  = data_c;
    assign tx.out_last  = last_c;

endmodule

// File: tb/tb_inst_trace_tx.sv
module tb_inst_trace_tx;
    localparam int PID_T   = 2;
    localparam int DEPTH_T = 16;
`ifdef INST_TRACE_TSTAMP_EN
    localparam int   NW  = 4;
    localparam logic TSB = 1'b1;
`else
    localparam int   NW  = 3;
    localparam logic TSB = 1'b0;
`endif

    logic        gclk = 1'b0;
    logic        rstn = 1'b0;
    logic        trace_en = 1'b0;
    logic        tr_valid = 1'b0;
    logic [4:0]  tr_tid = '0;
    logic [31:0] tr_pc = '0;
    logic [31:0] tr_inst = '0;
    logic        tr_replay = 1'b0;
    logic        tr_annul = 1'b0;
    logic        tr_dma = 1'b0;
    logic        tr_uc = 1'b0;
    logic [7:0]  tr_upc = '0;
    logic [7:0]  drop_cnt;

    inst_trace_tx_if tx_if ();

    inst_trace_tx #(.PID(PID_T), .DEPTH(DEPTH_T), .TIDW(5), .UPCW(8)) dut (
        .gclk(gclk), .rstn(rstn), .trace_en(trace_en), .tr_valid(tr_valid),
        .tr_tid(tr_tid), .tr_pc(tr_pc), .tr_inst(tr_inst),
        .tr_replay(tr_replay), .tr_annul(tr_annul), .tr_dma(tr_dma), .tr_uc(tr_uc),
        .tr_upc(tr_upc), .drop_cnt(drop_cnt), .tx(tx_if)
    );

    always #5 gclk = ~gclk;

    int nerr = 0;
    int nchk = 0;

    // Reference model: queue of pending records (each as its expected words).
    logic [127:0] mq[$];
    int           widx;
    logic [7:0]   m_seq;
    logic         m_ovf;
    logic [7:0]   m_drop;
    logic         m_busy;
    logic [31:0]  m_ts;
    logic         p_stall;
    logic [31:0]  p_data;
    logic         p_last;
    logic [31:0]  hdr_log[$];
    logic [31:0]  word_log[$];

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        widx    = 0;
        m_seq   = '0;
        m_ovf   = 1'b0;
        m_drop  = '0;
        m_busy  = 1'b0;
        m_ts    = '0;
        p_stall = 1'b0;
        p_data  = '0;
        p_last  = 1'b0;
    endtask

    // Entered at a falling edge; asserts reset mid-cycle, leaves at a falling edge.
    task automatic do_reset();
        trace_en = 1'b0;
        tr_valid = 1'b0;
        #2;
        rstn = 1'b0;
        #1;
        check_val("rst_valid", 32'(tx_if.out_valid), 32'd0);
        check_val("rst_data", tx_if.out_data, 32'd0);
        check_val("rst_last", 32'(tx_if.out_last), 32'd0);
        check_val("rst_drop", 32'(drop_cnt), 32'd0);
        model_clear();
        @(negedge gclk);
        rstn = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, check, update model, advance.
    task automatic step(input logic en, input logic vld, input logic [4:0] tid,
                        input logic [31:0] pc, input logic [31:0] inst,
                        input logic [3:0] flags, input logic [7:0] upc, input logic rdy);
        logic         hs, pop, cap;
        int           cnt_b;
        logic [127:0] cur, rec;
        logic [31:0]  h;
        trace_en  = en;
        tr_valid  = vld;
        tr_tid    = tid;
        tr_pc     = pc;
        tr_inst   = inst;
        {tr_replay, tr_annul, tr_dma, tr_uc} = flags;
        tr_upc    = upc;
        tx_if.out_ready = rdy;
        #1;
        check_val("valid", 32'(tx_if.out_valid), 32'(m_busy));
        check_val("drop_cnt", 32'(drop_cnt), 32'(m_drop));
        if (p_stall) begin
            check_val("stall_valid", 32'(tx_if.out_valid), 32'd1);
            check_val("stall_data", tx_if.out_data, p_data);
            check_val("stall_last", 32'(tx_if.out_last), 32'(p_last));
        end
        hs    = tx_if.out_valid && rdy;
        cnt_b = mq.size();
        pop   = 1'b0;
        if (hs) begin
            if (cnt_b == 0) begin
                check_val("word_pending", 32'(cnt_b), 32'd1);
            end else begin
                cur = mq[0];
                check_val("word", tx_if.out_data, cur[widx*32 +: 32]);
                check_val("last", 32'(tx_if.out_last), 32'(widx == NW-1));
                if (widx == 0) hdr_log.push_back(tx_if.out_data);
                word_log.push_back(tx_if.out_data);
                widx++;
                if (widx == NW) begin
                    widx = 0;
                    pop  = 1'b1;
                    void'(mq.pop_front());
                end
            end
        end
        p_stall = tx_if.out_valid && !rdy;
        p_data  = tx_if.out_data;
        p_last  = tx_if.out_last;
        cap = en && vld;
        if (cap) begin
            if (cnt_b < DEPTH_T || pop) begin
                h = {4'(PID_T), flags, upc, m_seq, TSB, m_ovf, 1'b0, tid};
                rec = '0;
                rec[31:0]   = h;
                rec[63:32]  = pc;
                rec[95:64]  = inst;
                if (NW == 4) rec[127:96] = m_ts;
                mq.push_back(rec);
                m_ovf = 1'b0;
            end else begin
                m_ovf = 1'b1;
                if (m_drop != 8'hFF) m_drop++;
            end
            m_seq++;
        end
        if (!m_busy) m_busy = (cnt_b != 0);
        else if (pop) m_busy = (mq.size() != 0);
        m_ts++;
        @(negedge gclk);
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 4'd0, 8'd0, rdy);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tx_if.out_ready = 1'b0;
        model_clear();
        @(negedge gclk);
        do_reset();

        // Single record.
        hdr_log.delete(); word_log.delete();
        step(1'b1, 1'b1, 5'd3, 32'h40001000, 32'h9DE3BFA0, 4'b0000, 8'h00, 1'b1);
        repeat (NW + 3) idle(1'b1);
        check_val("single_nwords", 32'(word_log.size()), 32'(NW));
        if (word_log.size() >= 3) begin
            check_val("single_hdr", word_log[0], 32'h20000003 | (32'(TSB) << 7));
            check_val("single_pc", word_log[1], 32'h40001000);
            check_val("single_inst", word_log[2], 32'h9DE3BFA0);
        end

        // Flags and PID, second capture -> seq 1.
        hdr_log.delete(); word_log.delete();
        step(1'b1, 1'b1, 5'd1, 32'h12345678, 32'h01000000, 4'b1011, 8'h5A, 1'b1);
        repeat (NW + 3) idle(1'b1);
        check_val("flags_nhdr", 32'(hdr_log.size()), 32'd1);
        if (hdr_log.size() >= 1)
            check_val("flags_hdr", hdr_log[0], 32'h2B5A0101 | (32'(TSB) << 7));

        // Backpressure mid-record.
        word_log.delete();
        step(1'b1, 1'b1, 5'd7, 32'hCAFE0000, 32'hBEEF0001, 4'b0100, 8'h11, 1'b1);
        idle(1'b1);
        idle(1'b1);
        repeat (5) idle(1'b0);
        repeat (NW + 2) idle(1'b1);
        check_val("bp_nwords", 32'(word_log.size()), 32'(NW));

        // Async reset after the PC word.
        step(1'b1, 1'b1, 5'd9, 32'hAAAA0000, 32'h55550000, 4'b0000, 8'h00, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        do_reset();
        hdr_log.delete();
        step(1'b1, 1'b1, 5'd4, 32'h00000100, 32'h00000200, 4'b0000, 8'h00, 1'b1);
        repeat (NW + 3) idle(1'b1);
        check_val("rst_nhdr", 32'(hdr_log.size()), 32'd1);
        if (hdr_log.size() >= 1) check_val("rst_seq", 32'(hdr_log[0][15:8]), 32'd0);

        // Overflow: 20 captures with the stream stalled.
        do_reset();
        hdr_log.delete();
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b1, 5'(i), 32'h1000 + 32'(i), 32'h2000 + 32'(i), 4'b0000, 8'h00, 1'b0);
        idle(1'b0);
        check_val("ovf_drop", 32'(drop_cnt), 32'd4);
        repeat (DEPTH_T * NW + 4) idle(1'b1);
        check_val("ovf_nhdr", 32'(hdr_log.size()), 32'd16);
        for (int i = 0; i < 16 && i < hdr_log.size(); i++) begin
            check_val("ovf_seq", 32'(hdr_log[i][15:8]), 32'(i));
            check_val("ovf_bit", 32'(hdr_log[i][6]), 32'd0);
        end
        step(1'b1, 1'b1, 5'd2, 32'h3000, 32'h4000, 4'b0000, 8'h00, 1'b1);
        repeat (NW + 3) idle(1'b1);
        if (hdr_log.size() >= 17) begin
            check_val("post_ovf_seq", 32'(hdr_log[16][15:8]), 32'd20);
            check_val("post_ovf_bit", 32'(hdr_log[16][6]), 32'd1);
        end else begin
            check_val("post_ovf_nhdr", 32'(hdr_log.size()), 32'd17);
        end

`ifdef INST_TRACE_TSTAMP_EN
        // Timestamp captured at counter value 37.
        do_reset();
        repeat (37) idle(1'b1);
        word_log.delete();
        step(1'b1, 1'b1, 5'd5, 32'h5000, 32'h6000, 4'b0000, 8'h00, 1'b1);
        repeat (NW + 3) idle(1'b1);
        check_val("ts_nwords", 32'(word_log.size()), 32'd4);
        if (word_log.size() >= 4) begin
            check_val("ts_bit", 32'(word_log[0][7]), 32'd1);
            check_val("ts_word", word_log[3], 32'd37);
        end
`endif

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
                 5'($urandom_range(0, 31)), 32'($urandom), 32'($urandom),
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0);
        repeat (DEPTH_T * NW + 8) idle(1'b1);
        check_val("rand_drained", 32'(mq.size()), 32'd0);

        // drop_cnt saturation.
        for (int i = 0; i < 300; i++)
            step(1'b1, 1'b1, 5'd0, 32'(i), 32'(i), 4'b0000, 8'h00, 1'b0);
        idle(1'b0);
        check_val("drop_sat", 32'(drop_cnt), 32'd255);
        repeat (DEPTH_T * NW + 8) idle(1'b1);
        check_val("sat_drained", 32'(mq.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
